// File: rtl/spi_mem_arbiter_if.sv
// Bundles the fetch port, data port and spi_flash_controller side of spi_mem_arbiter.
// slave is the arbiter's view; master is the requesters plus the controller.
interface spi_mem_arbiter_if;
  logic        i_req_in;
  logic [15:0] i_addr_in;
  logic [15:0] i_data_out;
  logic        i_done_out;
  logic        d_req_in;
  logic        d_we_in;
  logic [15:0] d_addr_in;
  logic [7:0]  d_wdata_in;
  logic [7:0]  d_rdata_out;
  logic        d_done_out;
  logic [15:0] mem_addr_out;
  logic        mem_addr_valid_out;
  logic [1:0]  mem_type_out;
  logic [7:0]  mem_wdata_out;
  logic [15:0] mem_flash_data_in;
  logic [7:0]  mem_psram_data_in;
  logic        mem_busy_in;

  modport slave (
    input  i_req_in, i_addr_in, d_req_in, d_we_in, d_addr_in, d_wdata_in,
    input  mem_flash_data_in, mem_psram_data_in, mem_busy_in,
    output i_data_out, i_done_out, d_rdata_out, d_done_out,
    output mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
  );

  modport master (
    output i_req_in, i_addr_in, d_req_in, d_we_in, d_addr_in, d_wdata_in,
    output mem_flash_data_in, mem_psram_data_in, mem_busy_in,
    input  i_data_out, i_done_out, d_rdata_out, d_done_out,
    input  mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Round-robin fetch/data arbiter feeding one spi_flash_controller issue port.
// Define SPI_ARB_FETCH_BUF_EN to add a single-entry fetch word buffer.
module spi_mem_arbiter (
  input logic             clk_in,
  input logic             reset_n_in,
  spi_mem_arbiter_if.slave bus
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssue    = 3'd1;
  localparam logic [2:0] StWaitBusy = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StRespond  = 3'd4;

  localparam logic [1:0] TypeImemRead  = 2'd0;
  localparam logic [1:0] TypeDmemRead  = 2'd1;
  localparam logic [1:0] TypeDmemWrite = 2'd2;

  localparam logic GrantFetch = 1'b0;
  localparam logic GrantData  = 1'b1;

  logic [2:0]  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  type_q, type_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] i_data_q, i_data_d;
  logic [7:0]  d_rdata_q, d_rdata_d;

  logic        fetch_sel, data_sel;
  logic        buf_hit;
  logic [15:0] buf_word;
  logic        buf_fill;

`ifdef SPI_ARB_FETCH_BUF_EN
  logic        buf_valid_q;
  logic [14:0] buf_tag_q;
  logic [15:0] buf_data_q;

  assign buf_hit  = buf_valid_q && (buf_tag_q == bus.i_addr_in[15:1]);
  assign buf_word = buf_data_q;

  // Never invalidated after reset: PSRAM writes cannot alias flash contents.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if (buf_fill) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= addr_q[15:1];
      buf_data_q  <= bus.mem_flash_data_in;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_word = 16'h0000;
`endif

  // Ties go to the port that did not win last time.
  assign fetch_sel = bus.i_req_in && (!bus.d_req_in || (last_grant_q == GrantData));
  assign data_sel  = bus.d_req_in && !fetch_sel;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    type_d       = type_q;
    wdata_d      = wdata_q;
    i_data_d     = i_data_q;
    d_rdata_d    = d_rdata_q;
    buf_fill     = 1'b0;

    case (state_q)
      StIdle: begin
        if (fetch_sel) begin
          grant_d = GrantFetch;
          if (buf_hit) begin
            i_data_d = buf_word;
            state_d  = StRespond;
          end else begin
            last_grant_d = GrantFetch;
            addr_d       = {bus.i_addr_in[15:1], 1'b0};
            type_d       = TypeImemRead;
            state_d      = StIssue;
          end
        end else if (data_sel) begin
          grant_d      = GrantData;
          last_grant_d = GrantData;
          addr_d       = bus.d_addr_in;
          if (bus.d_we_in) begin
            type_d  = TypeDmemWrite;
            wdata_d = bus.d_wdata_in;
          end else begin
            type_d = TypeDmemRead;
          end
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWaitBusy;
      StWaitBusy: begin
        if (bus.mem_busy_in) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!bus.mem_busy_in) begin
          if (type_q == TypeImemRead) begin
            i_data_d = bus.mem_flash_data_in;
            buf_fill = 1'b1;
          end else if (type_q == TypeDmemRead) begin
            d_rdata_d = bus.mem_psram_data_in;
          end
          state_d = StRespond;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= StIdle;
      grant_q      <= GrantFetch;
      last_grant_q <= GrantData;
      addr_q       <= '0;
      type_q       <= TypeImemRead;
      wdata_q      <= '0;
      i_data_q     <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      type_q       <= type_d;
      wdata_q      <= wdata_d;
      i_data_q     <= i_data_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_addr_out       = addr_q;
  assign bus.mem_type_out       = type_q;
  assign bus.mem_wdata_out      = wdata_q;
  assign bus.mem_addr_valid_out = (state_q == StIssue);
  assign bus.i_data_out         = i_data_q;
  assign bus.d_rdata_out        = d_rdata_q;
  assign bus.i_done_out         = (state_q == StRespond) && (grant_q == GrantFetch);
  assign bus.d_done_out         = (state_q == StRespond) && (grant_q == GrantData);

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed + randomized bench for spi_mem_arbiter with a behavioural controller/PSRAM model.
module tb_spi_mem_arbiter;

`ifdef SPI_ARB_FETCH_BUF_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  spi_mem_arbiter_if bus ();

  spi_mem_arbiter dut (
    .clk_in    (clk),
    .reset_n_in(rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash content: a fixed function of the word address.
  function automatic logic [15:0] flash_word(input logic [15:0] a);
    return {a[15:1], 1'b0} ^ 16'hA45A;
  endfunction

  // Controller model: busy the edge after valid, held for a random number of edges.
  logic [7:0]  ctrl_mem [0:255];
  logic [15:0] lat_addr;
  logic [1:0]  lat_type;
  logic [7:0]  lat_wdata;
  int          cnt;
  int          last_len;
  int          issue_cnt;
  int          force_len;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_busy_in       <= 1'b0;
      bus.mem_flash_data_in <= '0;
      bus.mem_psram_data_in <= '0;
      cnt                   <= 0;
    end else if (bus.mem_addr_valid_out) begin
      int len;
      len = (force_len != 0) ? force_len : int'($urandom_range(1, 5));
      bus.mem_busy_in <= 1'b1;
      lat_addr        <= bus.mem_addr_out;
      lat_type        <= bus.mem_type_out;
      lat_wdata       <= bus.mem_wdata_out;
      cnt             <= len;
      last_len        <= len;
      issue_cnt       <= issue_cnt + 1;
    end else if (bus.mem_busy_in) begin
      if (cnt == 1) begin
        bus.mem_busy_in <= 1'b0;
        if (lat_type == 2'd0) bus.mem_flash_data_in <= flash_word(lat_addr);
        else if (lat_type == 2'd1) bus.mem_psram_data_in <= ctrl_mem[lat_addr[7:0]];
        else ctrl_mem[lat_addr[7:0]] <= lat_wdata;
      end
      cnt <= cnt - 1;
    end
  end

  int   both_done_err;
  int   long_valid_err;
  logic prev_valid;
  always @(negedge clk) begin
    if (bus.i_done_out && bus.d_done_out) both_done_err <= both_done_err + 1;
    if (bus.mem_addr_valid_out && prev_valid) long_valid_err <= long_valid_err + 1;
    prev_valid <= bus.mem_addr_valid_out;
  end

  // Reference state
  logic [7:0]  ref_psram [0:255];
  logic        ref_buf_valid;
  logic [14:0] ref_buf_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem"}, {5'd0, bus.mem_addr_out, bus.mem_addr_valid_out, bus.mem_type_out,
                          bus.mem_wdata_out}, 32'd0);
    check({tag, "_resp"}, {6'd0, bus.i_data_out, bus.i_done_out, bus.d_rdata_out,
                           bus.d_done_out}, 32'd0);
  endtask

  // kind: 0 fetch, 1 data read, 2 data write. Called at a negedge.
  task automatic run_txn(input int kind, input logic [15:0] addr, input logic [7:0] wdata);
    int   issues0;
    int   cyc;
    logic done;
    logic hit;
    hit     = (kind == 0) && BufEn && ref_buf_valid && (ref_buf_tag == addr[15:1]);
    issues0 = issue_cnt;
    if (kind == 0) begin
      bus.i_req_in  = 1'b1;
      bus.i_addr_in = addr;
    end else begin
      bus.d_req_in   = 1'b1;
      bus.d_we_in    = (kind == 2);
      bus.d_addr_in  = addr;
      bus.d_wdata_in = wdata;
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      done = (kind == 0) ? bus.i_done_out : bus.d_done_out;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    if (kind == 0) begin
      check("fetch_data", {16'd0, bus.i_data_out}, {16'd0, flash_word(addr)});
      if (hit) begin
        check("hit_latency", cyc, 1);
        check("hit_no_issue", issue_cnt, issues0);
      end else begin
        check("miss_issue", issue_cnt, issues0 + 1);
        check("miss_latency", cyc, last_len + 3);
        check("fetch_addr", {16'd0, lat_addr}, {16'd0, addr[15:1], 1'b0});
        check("fetch_type", {30'd0, lat_type}, 32'd0);
      end
      ref_buf_valid = 1'b1;
      ref_buf_tag   = addr[15:1];
    end else begin
      check("data_issue", issue_cnt, issues0 + 1);
      check("data_latency", cyc, last_len + 3);
      check("data_addr", {16'd0, lat_addr}, {16'd0, addr});
      if (kind == 1) begin
        check("data_type_rd", {30'd0, lat_type}, 32'd1);
        check("rdata", {24'd0, bus.d_rdata_out}, {24'd0, ref_psram[addr[7:0]]});
      end else begin
        check("data_type_wr", {30'd0, lat_type}, 32'd2);
        check("wdata", {24'd0, lat_wdata}, {24'd0, wdata});
        ref_psram[addr[7:0]] = wdata;
      end
    end
    bus.i_req_in = 1'b0;
    bus.d_req_in = 1'b0;
    @(negedge clk);
    check("done_pulse", {30'd0, bus.i_done_out, bus.d_done_out}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_buf_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] faddr;
    int          cyc;
    int          who;
    logic [15:0] fset [4];
    tests = 0; fails = 0;
    both_done_err = 0; long_valid_err = 0; prev_valid = 1'b0;
    issue_cnt = 0; last_len = 0; force_len = 0;
    for (int i = 0; i < 256; i++) begin
      ctrl_mem[i]  = 8'h00;
      ref_psram[i] = 8'h00;
    end
    ref_buf_valid = 1'b0; ref_buf_tag = '0;
    bus.i_req_in = 1'b0; bus.i_addr_in = '0;
    bus.d_req_in = 1'b0; bus.d_we_in = 1'b0; bus.d_addr_in = '0; bus.d_wdata_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(0, 16'h0101, 8'h00);
    check("fetch_a55a", {16'd0, bus.i_data_out}, 32'h0000A55A);
    run_txn(2, 16'h1234, 8'h5C);
    run_txn(1, 16'h1234, 8'h00);
    check("rdata_5c", {24'd0, bus.d_rdata_out}, 32'h5C);

    // Asynchronous reset while waiting for busy to fall
    force_len    = 8;
    bus.i_req_in  = 1'b1;
    bus.i_addr_in = 16'h0222;
    cyc = 0;
    while (!bus.mem_busy_in && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_seen", {31'd0, bus.mem_busy_in}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    bus.i_req_in = 1'b0;
    force_len    = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_buf_valid = 1'b0;
    @(negedge clk);
    run_txn(0, 16'h0222, 8'h00);

    run_txn(0, 16'h0040, 8'h00);
    run_txn(0, 16'h0040, 8'h00);

    // Round-robin with both ports continuously re-requesting
    pulse_reset();
    faddr = 16'h1000;
    bus.i_req_in = 1'b1; bus.i_addr_in = faddr;
    bus.d_req_in = 1'b1; bus.d_we_in = 1'b0; bus.d_addr_in = 16'h0034;
    for (int k = 0; k < 6; k++) begin
      cyc = 0;
      while (!(bus.i_done_out || bus.d_done_out) && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      who = bus.d_done_out ? 1 : (bus.i_done_out ? 0 : 2);
      check("rr_grant", who, k % 2);
      if (who == 0) begin
        check("rr_fetch_data", {16'd0, bus.i_data_out}, {16'd0, flash_word(faddr)});
        bus.i_req_in = 1'b0;
      end else begin
        check("rr_rdata", {24'd0, bus.d_rdata_out}, {24'd0, ref_psram[8'h34]});
        bus.d_req_in = 1'b0;
      end
      @(negedge clk);
      if (k < 5) begin
        if (who == 0) begin
          faddr         = faddr + 16'd2;
          bus.i_addr_in = faddr;
          bus.i_req_in  = 1'b1;
        end else begin
          bus.d_req_in = 1'b1;
        end
      end
    end
    bus.i_req_in = 1'b0; bus.d_req_in = 1'b0;
    ref_buf_valid = 1'b1;
    ref_buf_tag   = faddr[15:1];
    repeat (2) @(negedge clk);

    // Randomized mix with a small fetch address set so buffer hits recur
    fset[0] = 16'h0040; fset[1] = 16'h0043; fset[2] = 16'h0100; fset[3] = 16'h0101;
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      if (kind == 0) run_txn(0, fset[$urandom_range(0, 3)], 8'h00);
      else run_txn(kind, 16'($urandom), 8'($urandom));
    end

    check("never_both_done", both_done_err, 0);
    check("valid_single_cycle", long_valid_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
